// File: rtl/fetch_redirect_ctrl.sv
// Purpose: single-outstanding instruction fetch with a one-entry output buffer and branch/jump redirect.
// Latency: request issues the cycle after the buffer frees; instruction is buffered the cycle after i_imem_ack.
// Backpressure: no new fetch while the buffer is full and i_inst_ready is low; the request address is held until ack.
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_B_J_result,
    input  logic [31:0] i_target,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_inst_ready,
    output logic        o_flush
);

    localparam logic [1:0] S_WAIT = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] req_addr;
    logic [31:0] tgt_aligned;
    logic        handshake;

    assign tgt_aligned = {i_target[31:2], 2'b00};
    assign handshake   = o_inst_valid && i_inst_ready;
    assign o_imem_req  = (state == S_REQ) || (state == S_DROP);
    assign o_imem_addr = req_addr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_WAIT;
            pc           <= RESET_PC;
            req_addr     <= RESET_PC;
            o_inst_valid <= 1'b0;
            o_inst       <= 32'h0;
            o_inst_pc    <= 32'h0;
            o_flush      <= 1'b0;
        end else begin
            o_flush <= i_B_J_result;
            if (handshake) begin
                o_inst_valid <= 1'b0;
            end
            // Redirect squashes the buffer; a same-cycle reload below is suppressed.
            if (i_B_J_result) begin
                pc           <= tgt_aligned;
                o_inst_valid <= 1'b0;
            end
            case (state)
                S_WAIT: begin
                    if (i_B_J_result) begin
                        req_addr <= tgt_aligned;
                        state    <= S_REQ;
                    end else if (!o_inst_valid || handshake) begin
                        req_addr <= pc;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_imem_ack) begin
                        if (i_B_J_result) begin
                            req_addr <= tgt_aligned;
                        end else begin
                            o_inst_valid <= 1'b1;
                            o_inst       <= i_imem_rdata;
                            o_inst_pc    <= req_addr;
                            pc           <= req_addr + 32'd4;
                            state        <= S_WAIT;
                        end
                    end else if (i_B_J_result) begin
                        // The memory still owes a response for the stale address.
                        state <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (i_imem_ack) begin
                        req_addr <= i_B_J_result ? tgt_aligned : pc;
                        state    <= S_REQ;
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Scoreboarded bench for fetch_redirect_ctrl: stimulus pushes expected fetch addresses and
// instructions; a negedge monitor pops and compares on every ack and decode handshake.
module tb_fetch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bj = 1'b0;
    logic [31:0] tgt = 32'h0;
    logic        req;
    logic [31:0] addr;
    logic        ack = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        ready = 1'b0;
    logic        flush;

    logic        req2;
    logic [31:0] addr2;
    logic        ack2 = 1'b0;
    logic [31:0] rdata2 = 32'h0;
    logic        valid2;
    logic [31:0] inst2;
    logic [31:0] inst_pc2;
    logic        flush2;

    int   checks = 0;
    int   failures = 0;
    int   grant = 0;
    int   acks_done = 0;
    int   lat = 0;
    int   mem_cnt = 0;
    int   grant2 = 0;
    int   acks2_done = 0;
    logic ack_force = 1'b0;
    logic started = 1'b0;
    logic prev_bj = 1'b0;
    logic prev_rst = 1'b1;

    logic [31:0] exp_req_q [$];
    logic [63:0] exp_inst_q [$];
    logic [31:0] exp_req2_q [$];
    logic [63:0] exp_inst2_q [$];

    always #5 clk = ~clk;

    fetch_redirect_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_B_J_result (bj),
        .i_target     (tgt),
        .o_imem_req   (req),
        .o_imem_addr  (addr),
        .i_imem_ack   (ack),
        .i_imem_rdata (rdata),
        .o_inst_valid (valid),
        .o_inst       (inst),
        .o_inst_pc    (inst_pc),
        .i_inst_ready (ready),
        .o_flush      (flush)
    );

    fetch_redirect_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_B_J_result (1'b0),
        .i_target     (32'h0),
        .o_imem_req   (req2),
        .o_imem_addr  (addr2),
        .i_imem_ack   (ack2),
        .i_imem_rdata (rdata2),
        .o_inst_valid (valid2),
        .o_inst       (inst2),
        .o_inst_pc    (inst_pc2),
        .i_inst_ready (1'b1),
        .o_flush      (flush2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h00C0_FFEE;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_fetch(input logic [31:0] a, input logic delivered);
        exp_req_q.push_back(a);
        if (delivered) exp_inst_q.push_back({a, mem_word(a)});
    endtask

    task automatic wait_req(input logic [31:0] a, input int bound);
        int n = 0;
        while (!(req && addr == a) && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(req && addr == a)) begin
            failures++;
            $display("FAIL wait_req: req=%b addr=%h, wanted request to %h within %0d cycles", req, addr, a, bound);
        end
    endtask

    task automatic wait_req2(input logic [31:0] a, input int bound);
        int n = 0;
        while (!(req2 && addr2 == a) && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(req2 && addr2 == a)) begin
            failures++;
            $display("FAIL wait_req2: req=%b addr=%h, wanted request to %h within %0d cycles", req2, addr2, a, bound);
        end
    endtask

    task automatic wait_valid(input int bound);
        int n = 0;
        while (!valid && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!valid) begin
            failures++;
            $display("FAIL wait_valid: o_inst_valid=0, wanted 1 within %0d cycles", bound);
        end
    endtask

    task automatic check_drained();
        check("req_queue_left", 64'(exp_req_q.size()), 64'd0);
        check("inst_queue_left", 64'(exp_inst_q.size()), 64'd0);
        check("req2_queue_left", 64'(exp_req2_q.size()), 64'd0);
        check("inst2_queue_left", 64'(exp_inst2_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        cyc(1);
        rst = 1'b1;
        bj = 1'b0;
        tgt = 32'h0;
        ready = 1'b0;
        ack_force = 1'b0;
        cyc(1);
        @(negedge clk);
        started = 1'b1;
        check("rst_req", 64'(req), 64'd0);
        check("rst_addr", 64'(addr), 64'h0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_inst", {inst_pc, inst}, 64'h0);
        check("rst_flush", 64'(flush), 64'd0);
        check("rst_wrap_state", {28'h0, req2, valid2, flush2, 1'b0, addr2}, 64'h0000_0000_FFFF_FFFC);
        cyc(1);
        rst = 1'b0;
        cyc(1);
        @(negedge clk);
        check("first_req", {31'h0, req, addr}, {31'h0, 1'b1, 32'h0});
        check("first_req_wrap", {31'h0, req2, addr2}, {31'h0, 1'b1, 32'hFFFF_FFFC});
    endtask

    // Memory model for the main instance: acks after `lat` waiting cycles while grants remain.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            ack = 1'b0;
            if (ack_force) begin
                ack = 1'b1;
                rdata = 32'hDEAD_BEEF;
            end else if (req && acks_done < grant) begin
                if (mem_cnt >= lat) begin
                    ack = 1'b1;
                    rdata = mem_word(addr);
                    mem_cnt = 0;
                    acks_done++;
                end else begin
                    mem_cnt++;
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            ack2 = 1'b0;
            if (req2 && acks2_done < grant2) begin
                ack2 = 1'b1;
                rdata2 = mem_word(addr2);
                acks2_done++;
            end
        end
    end

    // Monitor: flush/valid follow last cycle's redirect; acks and handshakes pop the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check("flush", 64'(flush), 64'(prev_bj && !prev_rst));
                if (prev_bj && !prev_rst) check("valid_after_redirect", 64'(valid), 64'd0);
                if (req && ack && !rst) begin
                    if (exp_req_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL imem_ack: unexpected ack at addr %h, none expected", addr);
                    end else begin
                        check("imem_addr", 64'(addr), 64'(exp_req_q.pop_front()));
                    end
                end
                if (valid && ready && !bj && !rst) begin
                    if (exp_inst_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL inst: unexpected handshake pc %h inst %h, none expected", inst_pc, inst);
                    end else begin
                        check("inst_pc_data", {inst_pc, inst}, exp_inst_q.pop_front());
                    end
                end
                if (req2 && ack2 && !rst) begin
                    if (exp_req2_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL wrap_ack: unexpected ack at addr %h, none expected", addr2);
                    end else begin
                        check("wrap_imem_addr", 64'(addr2), 64'(exp_req2_q.pop_front()));
                    end
                end
                if (valid2 && !rst) begin
                    if (exp_inst2_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL wrap_inst: unexpected handshake pc %h inst %h, none expected", inst_pc2, inst2);
                    end else begin
                        check("wrap_inst_pc_data", {inst_pc2, inst2}, exp_inst2_q.pop_front());
                    end
                end
            end
            prev_bj = bj;
            prev_rst = rst;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        // Sequential fetch 0x0, 0x4, 0x8 with ack one cycle into each request.
        do_reset();
        lat = 1;
        ready = 1'b1;
        push_fetch(32'h0, 1'b1);
        push_fetch(32'h4, 1'b1);
        push_fetch(32'h8, 1'b1);
        grant += 3;
        wait_req(32'hC, 40);
        check_drained();

        // Decode stall: buffer held, no request issued until ready.
        do_reset();
        lat = 0;
        push_fetch(32'h0, 1'b1);
        push_fetch(32'h4, 1'b1);
        grant += 2;
        wait_valid(20);
        repeat (5) begin
            @(negedge clk);
            check("stall_req", 64'(req), 64'd0);
            check("stall_inst", {inst_pc, inst}, {32'h0, mem_word(32'h0)});
        end
        cyc(1);
        ready = 1'b1;
        wait_req(32'h8, 20);
        check_drained();

        // Redirect to 0x100 while 0x8 is outstanding; stale ack arrives 3 cycles later.
        do_reset();
        lat = 1;
        ready = 1'b1;
        push_fetch(32'h0, 1'b1);
        push_fetch(32'h4, 1'b1);
        grant += 2;
        wait_req(32'h8, 40);
        cyc(1);
        bj = 1'b1;
        tgt = 32'h100;
        push_fetch(32'h8, 1'b0);
        push_fetch(32'h100, 1'b1);
        cyc(1);
        bj = 1'b0;
        tgt = 32'h0;
        @(negedge clk);
        check("drop_hold", {31'h0, req, addr}, {31'h0, 1'b1, 32'h8});
        lat = 3;
        grant += 2;
        repeat (3) begin
            @(negedge clk);
            check("stale_hold", {31'h0, req, addr}, {31'h0, 1'b1, 32'h8});
        end
        wait_req(32'h104, 40);
        check_drained();

        // Redirect to unaligned 0x203 in the same cycle as the ack of 0x0.
        do_reset();
        lat = 0;
        ready = 1'b1;
        push_fetch(32'h0, 1'b0);
        cyc(1);
        bj = 1'b1;
        tgt = 32'h203;
        grant += 1;
        cyc(1);
        bj = 1'b0;
        tgt = 32'h0;
        @(negedge clk);
        check("redir_ack_addr", {31'h0, req, addr}, {31'h0, 1'b1, 32'h200});
        check("redir_ack_valid", 64'(valid), 64'd0);
        push_fetch(32'h200, 1'b1);
        grant += 1;
        wait_req(32'h204, 20);
        check_drained();

        // RESET_PC at the top of the address space wraps to 0x0.
        do_reset();
        exp_req2_q.push_back(32'hFFFF_FFFC);
        exp_req2_q.push_back(32'h0);
        exp_inst2_q.push_back({32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)});
        exp_inst2_q.push_back({32'h0, mem_word(32'h0)});
        grant2 += 2;
        wait_req2(32'h4, 20);
        check_drained();

        // Reset mid-request; acks during and right after reset are ignored.
        do_reset();
        lat = 0;
        ready = 1'b1;
        push_fetch(32'h0, 1'b1);
        grant += 1;
        wait_req(32'h4, 20);
        cyc(1);
        rst = 1'b1;
        ack_force = 1'b1;
        cyc(1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_state", {30'h0, req, valid, addr}, 64'h0);
        cyc(1);
        ack_force = 1'b0;
        @(negedge clk);
        check("midrst_refetch", {30'h0, req, valid, addr}, {30'h0, 1'b1, 1'b0, 32'h0});
        push_fetch(32'h0, 1'b1);
        grant += 1;
        wait_req(32'h4, 20);
        check_drained();

        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
